// File: rtl/multi_port_reg_file.sv
// rtl/multi_port_reg_file.sv - two-read/one-write register file with busy scoreboard
// Clears all storage after reset before accepting operations.
module multi_port_reg_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  regWrite,
  input  logic [ADDR_WIDTH-1:0] writeReg,
  input  logic [DATA_WIDTH-1:0] writeData,
  input  logic                  reserve,
  input  logic [ADDR_WIDTH-1:0] reserveReg,
  input  logic [ADDR_WIDTH-1:0] readRegisterNumberOne,
  input  logic [ADDR_WIDTH-1:0] readRegisterNumberTwo,
  output logic [DATA_WIDTH-1:0] readDataNumberOne,
  output logic [DATA_WIDTH-1:0] readDataNumberTwo,
  output logic                  readBusyOne,
  output logic                  readBusyTwo,
  output logic                  ready,
  output logic                  zeroWriteError
);

  localparam int NUM_REGS = 2 ** ADDR_WIDTH;

  typedef enum logic {INIT, RUN} state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   counter;
  logic [NUM_REGS-1:0]     busy;
  logic [DATA_WIDTH-1:0]   storage [NUM_REGS];
  logic                    writeActive;

  assign writeActive = (state == RUN) && regWrite && (writeReg != '0);

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= INIT;
      counter        <= '0;
      busy           <= '0;
      ready          <= 1'b0;
      zeroWriteError <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          counter <= counter + 1'b1;
          if (&counter) begin
            state <= RUN;
            ready <= 1'b1;
          end
        end
        RUN: begin
          if (regWrite) begin
            if (writeReg != '0) busy[writeReg] <= 1'b0;
            else                zeroWriteError <= 1'b1;
          end
          // Placed after the write clear so a same-edge reservation wins.
          if (reserve && reserveReg != '0) busy[reserveReg] <= 1'b1;
        end
        default: state <= INIT;
      endcase
    end
  end

  // Storage has no reset; the INIT sweep zeroes it one entry per cycle.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (state == INIT)   storage[counter]  <= '0;
      else if (writeActive) storage[writeReg] <= writeData;
    end
  end

  always_comb begin
    readDataNumberOne = '0;
    readBusyOne       = 1'b0;
    if (state == RUN && readRegisterNumberOne != '0) begin
      if (writeActive && readRegisterNumberOne == writeReg) begin
        readDataNumberOne = writeData;
      end else begin
        readDataNumberOne = storage[readRegisterNumberOne];
        readBusyOne       = busy[readRegisterNumberOne];
      end
    end
  end

  always_comb begin
    readDataNumberTwo = '0;
    readBusyTwo       = 1'b0;
    if (state == RUN && readRegisterNumberTwo != '0) begin
      if (writeActive && readRegisterNumberTwo == writeReg) begin
        readDataNumberTwo = writeData;
      end else begin
        readDataNumberTwo = storage[readRegisterNumberTwo];
        readBusyTwo       = busy[readRegisterNumberTwo];
      end
    end
  end

endmodule

// File: tb/tb_multi_port_reg_file.sv
// tb/tb_multi_port_reg_file.sv - directed self-checking bench for multi_port_reg_file
module tb_multi_port_reg_file;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        regWrite = 1'b0;
  logic [4:0]  writeReg = '0;
  logic [31:0] writeData = '0;
  logic        reserve = 1'b0;
  logic [4:0]  reserveReg = '0;
  logic [4:0]  readRegisterNumberOne = '0;
  logic [4:0]  readRegisterNumberTwo = '0;
  logic [31:0] readDataNumberOne;
  logic [31:0] readDataNumberTwo;
  logic        readBusyOne;
  logic        readBusyTwo;
  logic        ready;
  logic        zeroWriteError;

  int checks = 0;
  int errors = 0;

  multi_port_reg_file dut (
    .clock                 (clock),
    .reset                 (reset),
    .regWrite              (regWrite),
    .writeReg              (writeReg),
    .writeData             (writeData),
    .reserve               (reserve),
    .reserveReg            (reserveReg),
    .readRegisterNumberOne (readRegisterNumberOne),
    .readRegisterNumberTwo (readRegisterNumberTwo),
    .readDataNumberOne     (readDataNumberOne),
    .readDataNumberTwo     (readDataNumberTwo),
    .readBusyOne           (readBusyOne),
    .readBusyTwo           (readBusyTwo),
    .ready                 (ready),
    .zeroWriteError        (zeroWriteError)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic doReset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    repeat (32) step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", ready); end
    checks++; if (zeroWriteError !== 1'b0) begin errors++; $display("FAIL reset_zwe got %b want 0", zeroWriteError); end
    checks++; if (readDataNumberOne !== 32'h0 || readDataNumberTwo !== 32'h0) begin
      errors++; $display("FAIL reset_data got %h/%h want 0/0", readDataNumberOne, readDataNumberTwo); end
    checks++; if (readBusyOne !== 1'b0 || readBusyTwo !== 1'b0) begin
      errors++; $display("FAIL reset_busy got %b/%b want 0/0", readBusyOne, readBusyTwo); end
    reset = 1'b0;
    for (int i = 1; i <= 32; i++) begin
      step();
      checks++;
      if (ready !== (i == 32)) begin errors++; $display("FAIL init_ready edge %0d got %b want %b", i, ready, (i == 32)); end
    end
    readRegisterNumberOne = 5'd5;
    readRegisterNumberTwo = 5'd31;
    #1;
    checks++; if (readDataNumberOne !== 32'h0 || readDataNumberTwo !== 32'h0) begin
      errors++; $display("FAIL cleared_data got %h/%h want 0/0", readDataNumberOne, readDataNumberTwo); end
  endtask

  task automatic test_write_bypass();
    regWrite = 1'b1; writeReg = 5'd5; writeData = 32'hDEADBEEF;
    readRegisterNumberOne = 5'd5; readRegisterNumberTwo = 5'd6;
    #1;
    checks++; if (readDataNumberOne !== 32'hDEADBEEF) begin errors++; $display("FAIL bypass_data got %h want deadbeef", readDataNumberOne); end
    checks++; if (readDataNumberTwo !== 32'h0) begin errors++; $display("FAIL bypass_other got %h want 0", readDataNumberTwo); end
    step();
    regWrite = 1'b0;
    #1;
    checks++; if (readDataNumberOne !== 32'hDEADBEEF) begin errors++; $display("FAIL stored_data got %h want deadbeef", readDataNumberOne); end
    readRegisterNumberTwo = 5'd5;
    #1;
    checks++; if (readDataNumberTwo !== 32'hDEADBEEF) begin errors++; $display("FAIL same_reg_two got %h want deadbeef", readDataNumberTwo); end
  endtask

  task automatic test_zero_write();
    regWrite = 1'b1; writeReg = 5'd0; writeData = 32'h1234;
    readRegisterNumberOne = 5'd0;
    #1;
    checks++; if (readDataNumberOne !== 32'h0) begin errors++; $display("FAIL zero_bypass got %h want 0", readDataNumberOne); end
    checks++; if (zeroWriteError !== 1'b0) begin errors++; $display("FAIL zwe_early got %b want 0", zeroWriteError); end
    step();
    regWrite = 1'b0;
    #1;
    checks++; if (readDataNumberOne !== 32'h0) begin errors++; $display("FAIL zero_read got %h want 0", readDataNumberOne); end
    for (int i = 0; i <= 10; i++) begin
      checks++;
      if (zeroWriteError !== 1'b1) begin errors++; $display("FAIL zwe_sticky cycle %0d got %b want 1", i, zeroWriteError); end
      step();
    end
    doReset();
    checks++; if (zeroWriteError !== 1'b0) begin errors++; $display("FAIL zwe_cleared got %b want 0", zeroWriteError); end
  endtask

  task automatic test_reserve();
    reserve = 1'b1; reserveReg = 5'd7;
    readRegisterNumberTwo = 5'd7;
    #1;
    checks++; if (readBusyTwo !== 1'b0) begin errors++; $display("FAIL busy_before got %b want 0", readBusyTwo); end
    step();
    reserve = 1'b0;
    #1;
    checks++; if (readBusyTwo !== 1'b1) begin errors++; $display("FAIL busy_set got %b want 1", readBusyTwo); end
    regWrite = 1'b1; writeReg = 5'd7; writeData = 32'h55;
    #1;
    checks++; if (readBusyTwo !== 1'b0 || readDataNumberTwo !== 32'h55) begin
      errors++; $display("FAIL busy_bypass got %b/%h want 0/55", readBusyTwo, readDataNumberTwo); end
    step();
    regWrite = 1'b0;
    #1;
    checks++; if (readBusyTwo !== 1'b0 || readDataNumberTwo !== 32'h55) begin
      errors++; $display("FAIL busy_cleared got %b/%h want 0/55", readBusyTwo, readDataNumberTwo); end
    regWrite = 1'b1; writeReg = 5'd9; writeData = 32'h99;
    reserve = 1'b1; reserveReg = 5'd9;
    step();
    regWrite = 1'b0; reserve = 1'b0;
    readRegisterNumberOne = 5'd9; readRegisterNumberTwo = 5'd9;
    #1;
    checks++; if (readBusyOne !== 1'b1 || readBusyTwo !== 1'b1) begin
      errors++; $display("FAIL reserve_wins got %b/%b want 1/1", readBusyOne, readBusyTwo); end
    checks++; if (readDataNumberOne !== 32'h99 || readDataNumberTwo !== 32'h99) begin
      errors++; $display("FAIL reserve_write_data got %h/%h want 99/99", readDataNumberOne, readDataNumberTwo); end
    reserve = 1'b1; reserveReg = 5'd0;
    step();
    reserve = 1'b0;
    readRegisterNumberOne = 5'd0;
    #1;
    checks++; if (readBusyOne !== 1'b0) begin errors++; $display("FAIL reserve_zero got %b want 0", readBusyOne); end
  endtask

  task automatic test_reset_mid_init();
    regWrite = 1'b1; writeReg = 5'd3; writeData = 32'hA5;
    step();
    regWrite = 1'b0;
    readRegisterNumberOne = 5'd3;
    #1;
    checks++; if (readDataNumberOne !== 32'hA5) begin errors++; $display("FAIL reg3_written got %h want a5", readDataNumberOne); end
    reset = 1'b1;
    step();
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL run_reset_ready got %b want 0", ready); end
    reset = 1'b0;
    repeat (10) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL init_reset_ready got %b want 0", ready); end
    repeat (31) step();
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL restart_edge31 got %b want 0", ready); end
    step();
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL restart_edge32 got %b want 1", ready); end
    checks++; if (readDataNumberOne !== 32'h0) begin errors++; $display("FAIL reg3_cleared got %h want 0", readDataNumberOne); end
  endtask

  task automatic test_init_ignore();
    reset = 1'b1;
    step();
    reset = 1'b0;
    regWrite = 1'b1; writeData = 32'hFFFF_FFFF;
    reserve = 1'b1; reserveReg = 5'd4;
    readRegisterNumberOne = 5'd4; readRegisterNumberTwo = 5'd4;
    for (int i = 1; i <= 32; i++) begin
      writeReg = (i % 2 == 1) ? 5'd4 : 5'd0;
      #1;
      if (i == 8) begin
        checks++;
        if (readDataNumberOne !== 32'h0 || readBusyOne !== 1'b0) begin
          errors++; $display("FAIL init_outputs got %h/%b want 0/0", readDataNumberOne, readBusyOne); end
      end
      step();
    end
    regWrite = 1'b0; reserve = 1'b0;
    #1;
    checks++; if (readDataNumberOne !== 32'h0 || readBusyTwo !== 1'b0) begin
      errors++; $display("FAIL init_ignored got %h/%b want 0/0", readDataNumberOne, readBusyTwo); end
    checks++; if (zeroWriteError !== 1'b0) begin errors++; $display("FAIL init_zwe got %b want 0", zeroWriteError); end
  endtask

  initial begin
    test_reset();
    test_write_bypass();
    test_zero_write();
    test_reserve();
    test_reset_mid_init();
    test_init_ignore();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
